// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, bus widths, address helper.
package imem_loader_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                    input logic [WORD_W-1:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// Latency: word_vld/word_dat are combinational in the cycle the 4th byte is taken.
// Backpressure: none; the parent gates in_vld with its own ready.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [BYTE_W-1:0] in_dat,
    output logic [1:0]        byte_idx,
    output logic              word_vld,
    output logic [WORD_W-1:0] word_dat
);

    logic [1:0]               byte_idx_q, byte_idx_d;
    logic [WORD_W-BYTE_W-1:0] shift_q, shift_d;

    always_comb begin
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        if (clr) begin
            byte_idx_d = 2'd0;
        end else if (in_vld) begin
            byte_idx_d = byte_idx_q + 2'd1;
            // Shift right so the first byte ends up in the least significant lane.
            shift_d    = {in_dat, shift_q[WORD_W-BYTE_W-1:BYTE_W]};
        end
    end

    assign byte_idx = byte_idx_q;
    assign word_vld = in_vld && !clr && (byte_idx_q == 2'd3);
    assign word_dat = {in_dat, shift_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= 2'd0;
            shift_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed word stream into imem, then releases the CPU with a reset pulse.
// Latency: imem write one cycle after a word's 4th byte; DONE one cycle after the last write.
// Backpressure: byte_ready low only in DONE/ERR and during the final word's write cycle.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        load_start,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_err,
    output logic [31:0] words_loaded
);

    localparam int                TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LIMIT    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [WORD_W-1:0] DEPTH_LIMIT = WORD_W'(DEPTH_WORDS);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   n_q, n_d;
    logic [WORD_W-1:0]   words_q, words_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                cpu_en_q, cpu_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                asm_clr;
    logic                counting;
    logic                timeout;
    logic [1:0]          byte_idx;
    logic                word_vld;
    logic [WORD_W-1:0]   word_dat;

    // Once all N words have been assembled, further bytes belong to nobody.
    assign byte_ready = (state_q == HDR) || ((state_q == DATA) && (words_q != n_q));
    assign accept     = byte_valid && byte_ready;

    byte_assembler u_asm (
        .clk      (clk),
        .rst      (rst),
        .clr      (asm_clr),
        .in_vld   (accept),
        .in_dat   (byte_data),
        .byte_idx (byte_idx),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        words_d  = words_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        asm_clr  = 1'b0;
        timeout  = 1'b0;
        to_cnt_d = '0;

        counting = ((state_q == HDR) && (byte_idx != 2'd0)) || (state_q == DATA);
        if (counting && !accept) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            timeout  = (to_cnt_d == TO_LIMIT);
        end

        case (state_q)
            HDR: begin
                if (word_vld) begin
                    n_d = word_dat;
                    if (word_dat == '0) begin
                        state_d = DONE;
                    end else if (word_dat > DEPTH_LIMIT) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                    asm_clr = 1'b1;
                end
            end
            DATA: begin
                if (word_vld) begin
                    we_d    = 1'b1;
                    addr_d  = word_addr(BASE_ADDR, words_q);
                    wdata_d = word_dat;
                    words_d = words_q + 32'd1;
                end else if (words_q == n_q) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = ERR;
                    asm_clr = 1'b1;
                end
            end
            DONE, ERR: begin
                if (load_start) begin
                    state_d = HDR;
                    words_d = '0;
                    asm_clr = 1'b1;
                end
            end
            default: state_d = HDR;
        endcase

        cpu_rst_d = (state_d == DONE) && (state_q != DONE);
        cpu_en_d  = (state_d == DONE) && (state_q == DONE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HDR;
            n_q       <= '0;
            words_q   <= '0;
            to_cnt_q  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b0;
            cpu_en_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            words_q   <= words_d;
            to_cnt_q  <= to_cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_en_q  <= cpu_en_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_en       = cpu_en_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule
